bcd_display_mux: RTL and testbench
==================================

# bcd_display_mux

Time-multiplexed 4-digit seven-segment driver that consumes the hundreds/tens/ones BCD digits produced by the calculator's binary-to-BCD converter, plus a sign flag. Latches the digits on a load strobe, scans one digit per refresh interval, applies optional leading-zero blanking, and drives active-low anode and segment lines on the board display.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit stays active (legal range ≥ 2)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- load  input  1  single-cycle strobe; captures ones/tens/hundreds/negative
- ones  input  4  BCD ones digit
- tens  input  4  BCD tens digit
- hundreds  input  4  BCD hundreds digit
- negative  input  1  result sign; 1 = show minus on leftmost digit
- lz_en  input  1  leading-zero blanking enable (sampled live, not latched)
- an  output  4  active-low anodes; an[0] = rightmost digit
- seg  output  7  active-low segments, seg[6:0] = {g,f,e,d,c,b,a}

## Operation
- Holding registers ones_q, tens_q, hundreds_q, neg_q: cleared by reset; loaded on any clk edge with load=1; otherwise hold. Inputs ignored when load=0.
- Refresh counter: 0..REFRESH_DIV-1, wraps to 0; on wrap, scan state advances.
- Scan FSM, 4 states, fixed order, wraps: S_ONES (an=1110) -> S_TENS (an=1101) -> S_HUND (an=1011) -> S_SIGN (an=0111) -> S_ONES.
- Digit content per state:
  - S_ONES: ones_q, never blanked.
  - S_TENS: tens_q; blank if lz_en=1 and hundreds_q=0 and tens_q=0.
  - S_HUND: hundreds_q; blank if lz_en=1 and hundreds_q=0.
  - S_SIGN: minus if neg_q=1, else blank.
- Blank digit: anode still driven for its slot, seg=7'h7F.
- Encodings (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; any value 10–15 = "E" = 06; minus = 3F; blank = 7F.
- Invalid BCD (>9) is never blanked, even under lz_en, so the fault is visible.
- load and counter wrap in the same cycle: both take effect; scan position is never disturbed by load.

## Timing
- an and seg are registered outputs.
- During reset and on the first edge with reset=1: an=4'b1111, seg=7'h7F, counter=0, state=S_ONES, holding registers=0.
- First edge with reset=0: an=1110, seg=pattern(ones_q) (7'h40 after reset).
- Each state shown for exactly REFRESH_DIV cycles; full frame = 4*REFRESH_DIV cycles.
- Load latency: load sampled at edge k; the new value appears on seg at edge k+1 if its digit is currently active.
- lz_en change reflected at the next edge.
- Reset asserted mid-scan: at the next edge, outputs return to the reset values above, the counter clears, and the holding registers clear; no partial frame resumes.

## Test plan
- Reset check, REFRESH_DIV=4: hold reset 3 cycles -> an=1111, seg=7F; release -> an=1110/seg=40 for 4 cycles, then an=1101/seg=40 (lz_en=0), 1011/40, 0111/7F, then repeats with a 16-cycle period.
- load hundreds=1, tens=2, ones=3, negative=0, lz_en=0 -> ones slot 30, tens 24, hundreds 79, sign 7F; change the inputs without load -> display unchanged.
- Leading zeros, lz_en=1: 0/0/7 -> 78, 7F, 7F; 0/5/0 -> ones 40, tens 12, hundreds 7F; 2/0/5 -> tens slot 40 (not blanked); toggle lz_en=0 -> zeros shown as 40 next edge.
- negative=1 with 0/4/2, lz_en=1 -> sign slot 3F, hundreds 7F, tens 19, ones 24; tens=4'hC loaded -> tens slot 06.
- Pulse load during S_HUND and at the counter wrap edge -> new hundreds visible one edge later; state sequence and 4-cycle dwell unaffected.
- Assert reset for one cycle while in S_TENS with nonzero held digits -> an=1111, seg=7F; next edge an=1110, seg=40; held digits read back 0.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed seven-segment driver for the calculator's BCD result.
// Latches digits and sign on load, scans one digit per refresh interval, blanks leading zeros.
module bcd_display_mux #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic [3:0] hundreds,
   input  logic       negative,
   input  logic       lz_en,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {
      S_ONES = 2'd0,
      S_TENS = 2'd1,
      S_HUND = 2'd2,
      S_SIGN = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic          wrap;
   logic [3:0]    ones_q;
   logic [3:0]    tens_q;
   logic [3:0]    hundreds_q;
   logic          neg_q;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic [3:0]    digit;
   logic          blank;
   logic          minus;

   // Active-low patterns; anything above 9 shows "E" so bad converter output is visible.
   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'h40;
         4'd1:    encode = 7'h79;
         4'd2:    encode = 7'h24;
         4'd3:    encode = 7'h30;
         4'd4:    encode = 7'h19;
         4'd5:    encode = 7'h12;
         4'd6:    encode = 7'h02;
         4'd7:    encode = 7'h78;
         4'd8:    encode = 7'h00;
         4'd9:    encode = 7'h10;
         default: encode = 7'h06;
      endcase
   endfunction

   assign wrap = (cnt == CW'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_ONES;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      an_next    = 4'b1111;
      digit      = 4'd0;
      blank      = 1'b0;
      minus      = 1'b0;
      case (state)
         S_ONES: begin
            an_next = 4'b1110;
            digit   = ones_q;
            if (wrap) state_next = S_TENS;
         end
         S_TENS: begin
            an_next = 4'b1101;
            digit   = tens_q;
            blank   = lz_en && (hundreds_q == 4'd0) && (tens_q == 4'd0);
            if (wrap) state_next = S_HUND;
         end
         S_HUND: begin
            an_next = 4'b1011;
            digit   = hundreds_q;
            blank   = lz_en && (hundreds_q == 4'd0);
            if (wrap) state_next = S_SIGN;
         end
         default: begin
            an_next = 4'b0111;
            minus   = neg_q;
            blank   = !neg_q;
            if (wrap) state_next = S_ONES;
         end
      endcase
      if (blank) begin
         seg_next = 7'h7F;
      end else if (minus) begin
         seg_next = 7'h3F;
      end else begin
         seg_next = encode(digit);
      end
   end

   // Outputs reflect the state and holding registers as they stood before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         ones_q     <= 4'd0;
         tens_q     <= 4'd0;
         hundreds_q <= 4'd0;
         neg_q      <= 1'b0;
         an         <= 4'b1111;
         seg        <= 7'h7F;
      end else begin
         cnt <= wrap ? '0 : cnt + CW'(1);
         if (load) begin
            ones_q     <= ones;
            tens_q     <= tens;
            hundreds_q <= hundreds;
            neg_q      <= negative;
         end
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with a 4-cycle refresh interval (16-cycle frame).
// pos tracks the frame position of the output visible after each tick.
module tb_bcd_display_mux;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] ones = 4'd0;
   logic [3:0] tens = 4'd0;
   logic [3:0] hundreds = 4'd0;
   logic       negative = 1'b0;
   logic       lz_en = 1'b0;
   logic [3:0] an;
   logic [6:0] seg;

   int tests = 0;
   int fails = 0;
   int pos = 15;

   bcd_display_mux #(.REFRESH_DIV(4)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .ones(ones),
      .tens(tens),
      .hundreds(hundreds),
      .negative(negative),
      .lz_en(lz_en),
      .an(an),
      .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      pos = (pos + 1) % 16;
   endtask

   task automatic check(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
      tests++;
      assert (an === an_exp && seg === seg_exp) else begin
         fails++;
         $error("FAIL %s pos=%0d: an=%b seg=%h, expected an=%b seg=%h",
                tag, pos, an, seg, an_exp, seg_exp);
      end
   endtask

   function automatic logic [3:0] slot_an(input int p);
      case (p / 4)
         0:       slot_an = 4'b1110;
         1:       slot_an = 4'b1101;
         2:       slot_an = 4'b1011;
         default: slot_an = 4'b0111;
      endcase
   endfunction

   task automatic check_frame(input string tag, input logic [6:0] s_ones, input logic [6:0] s_tens,
                              input logic [6:0] s_hund, input logic [6:0] s_sign);
      logic [6:0] e;
      for (int i = 0; i < 16; i++) begin
         tick();
         case (pos / 4)
            0:       e = s_ones;
            1:       e = s_tens;
            2:       e = s_hund;
            default: e = s_sign;
         endcase
         check(tag, slot_an(pos), e);
      end
   endtask

   task automatic go_to(input int p);
      for (int i = 0; i < 16 && pos != p; i++) tick();
   endtask

   // Loads so that the new values are fully in place for the next frame starting at pos 0.
   task automatic load_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                              input logic n);
      go_to(13);
      hundreds = h;
      tens     = t;
      ones     = o;
      negative = n;
      load     = 1'b1;
      tick();
      load = 1'b0;
      tick();
   endtask

   initial begin
      // Reset held for three edges
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_hold", 4'b1111, 7'h7F);
      end
      reset = 1'b0;
      pos   = 15;
      check_frame("post_reset_f0", 7'h40, 7'h40, 7'h40, 7'h7F);
      check_frame("post_reset_f1", 7'h40, 7'h40, 7'h40, 7'h7F);

      // Basic load, then input changes without load must not affect the display
      load_digits(4'd1, 4'd2, 4'd3, 1'b0);
      check_frame("load_123", 7'h30, 7'h24, 7'h79, 7'h7F);
      hundreds = 4'd9;
      tens     = 4'd8;
      ones     = 4'd7;
      negative = 1'b1;
      check_frame("no_load_hold", 7'h30, 7'h24, 7'h79, 7'h7F);

      // Leading-zero blanking
      lz_en = 1'b1;
      load_digits(4'd0, 4'd0, 4'd7, 1'b0);
      check_frame("lz_007", 7'h78, 7'h7F, 7'h7F, 7'h7F);
      load_digits(4'd0, 4'd5, 4'd0, 1'b0);
      check_frame("lz_050", 7'h40, 7'h12, 7'h7F, 7'h7F);
      load_digits(4'd2, 4'd0, 4'd5, 1'b0);
      check_frame("lz_205", 7'h12, 7'h40, 7'h24, 7'h7F);

      // lz_en is live: dropping it shows the zero at the very next edge
      load_digits(4'd0, 4'd0, 4'd7, 1'b0);
      go_to(5);
      check("lz_live_on", 4'b1101, 7'h7F);
      lz_en = 1'b0;
      tick();
      check("lz_live_off", 4'b1101, 7'h40);
      go_to(9);
      check("lz_live_off_hund", 4'b1011, 7'h40);

      // Sign and invalid BCD
      lz_en = 1'b1;
      load_digits(4'd0, 4'd4, 4'd2, 1'b1);
      check_frame("neg_042", 7'h24, 7'h19, 7'h7F, 7'h3F);
      load_digits(4'd0, 4'hC, 4'd2, 1'b1);
      check_frame("neg_0C2", 7'h24, 7'h06, 7'h7F, 7'h3F);
      load_digits(4'hF, 4'd0, 4'd0, 1'b0);
      check_frame("bad_hund", 7'h40, 7'h40, 7'h06, 7'h7F);

      // Load at the wrap edge into S_HUND, then load mid S_HUND
      lz_en = 1'b0;
      load_digits(4'd1, 4'd2, 4'd3, 1'b0);
      go_to(6);
      hundreds = 4'd4;
      load     = 1'b1;
      tick();
      load = 1'b0;
      check("wrap_load_tens", 4'b1101, 7'h24);
      tick();
      check("wrap_load_hund", 4'b1011, 7'h19);
      go_to(9);
      hundreds = 4'd5;
      load     = 1'b1;
      tick();
      load = 1'b0;
      check("mid_load_old", 4'b1011, 7'h19);
      tick();
      check("mid_load_new", 4'b1011, 7'h12);
      check_frame("after_loads", 7'h30, 7'h24, 7'h12, 7'h7F);

      // Single-cycle reset during S_TENS with nonzero digits
      go_to(5);
      check("pre_reset_tens", 4'b1101, 7'h24);
      reset = 1'b1;
      tick();
      check("mid_reset", 4'b1111, 7'h7F);
      reset = 1'b0;
      pos   = 15;
      check_frame("after_mid_reset", 7'h40, 7'h40, 7'h40, 7'h7F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
